// File: rtl/mem_access_unit.sv
// Initiator side of the word-wide data memory: lane-selected loads, word stores,
// and read-modify-write sub-word stores. Define MEM_MISALIGN_EXC_EN to flag misaligned accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_ADDR_MSB = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       Write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       Read_data
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merge_q, merge_d;
  logic              resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              accept, misalign, start_rmw;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;

  // Bits above the decoded range pass through untouched; aliasing is the memory's business.
  assign word_addr = {req_addr[ADDR_W-1:MEM_ADDR_MSB+1], req_addr[MEM_ADDR_MSB:2], 2'b00};

  always_comb begin
    misalign = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    case (req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = req_addr[0];
      default: misalign = (req_addr[1:0] != 2'b00);
    endcase
`endif
  end

  always_comb begin
    lane_byte = Read_data[{req_addr[1:0], 3'b000} +: 8];
    lane_half = Read_data[{req_addr[1], 4'b0000} +: 16];
    case (req_size)
      2'b00:   load_ext = {{24{req_signed & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{req_signed & lane_half[15]}}, lane_half};
      default: load_ext = Read_data;
    endcase
    merge_d = Read_data;
    if (req_size == 2'b00) merge_d[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    else                   merge_d[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_comb begin
    req_ready  = 1'b0;
    accept     = 1'b0;
    start_rmw  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    state_d    = state_q;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          req_ready = 1'b1;
          accept    = req_valid;
          if (req_valid && !misalign) begin
            Address = word_addr;
            if (!req_write) begin
              MemRead = 1'b1;
            end else if (!req_size[1]) begin
              MemRead   = 1'b1;
              start_rmw = 1'b1;
              state_d   = StRmwWr;
            end else begin
              MemWrite   = 1'b1;
              Write_data = req_wdata;
            end
          end
        end
        StRmwWr: begin
          MemWrite   = 1'b1;
          Address    = addr_q;
          Write_data = merge_q;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      // Sub-word stores respond after the write cycle, everything else right after acceptance.
      resp_valid_q <= (accept && !start_rmw) || (state_q == StRmwWr);
      resp_err_q   <= accept && misalign;
      if (accept && !req_write && !misalign) resp_rdata_q <= load_ext;
      if (start_rmw) begin
        merge_q <= merge_d;
        addr_q  <= word_addr;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 512-word behavioural data memory.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       Write_data, Read_data;
  logic              MemRead, MemWrite;

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_ADDR_MSB(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512] = '{default: 32'h0};
  assign Read_data = MemRead ? mem[Address[10:2]] : 32'h0;
  always @(posedge clk) if (MemWrite) mem[Address[10:2]] <= Write_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [512] = '{default: 32'h0};
  logic [31:0] last_rdata = 32'h0;
  int          checks = 0;
  int          failures = 0;
  int          w;
  logic        obs_read, obs_write;
  logic [31:0] obs_addr, obs_wdata;

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic sgn);
    logic [31:0] word, sh;
    word = ref_mem[a[10:2]];
    if (sz == 2'b00) begin
      sh = word >> {a[1:0], 3'b000};
      return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    end else if (sz == 2'b01) begin
      sh = word >> {a[1], 4'b0000};
      return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    end
    return word;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask, shifted;
    if (sz[1]) begin
      ref_mem[a[10:2]] = d;
    end else begin
      mask    = (sz == 2'b00) ? (32'h0000_00FF << {a[1:0], 3'b000})
                              : (32'h0000_FFFF << {a[1], 4'b0000});
      shifted = (sz == 2'b00) ? (d << {a[1:0], 3'b000}) : (d << {a[1], 4'b0000});
      ref_mem[a[10:2]] = (ref_mem[a[10:2]] & ~mask) | (shifted & mask);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request until accepted; records memory-side outputs of the accept cycle.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d, input bit hold,
                       input bit expect_resp, output int waits);
    bit   mis;
    exp_t e;
    mis = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = a;
    req_wdata  = d;
    waits      = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    obs_read  = MemRead;
    obs_write = MemWrite;
    obs_addr  = Address;
    obs_wdata = Write_data;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", a, req_ready);
    end
    if (expect_resp) begin
      e.err = mis;
      if (!wr && !mis) last_rdata = model_load(a, sz, sgn);
      else if (wr && !mis) model_store(a, sz, d);
      e.rdata = last_rdata;
      sb.push_back(e);
    end
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
    step();
  endtask

  always @(negedge clk) begin
    checks++;
    if (MemRead === 1'b1 && MemWrite === 1'b1) begin
      failures++;
      $display("FAIL rd_wr_exclusive got MemRead=1 MemWrite=1 want not both");
    end
    if (resp_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got resp_valid=1 want 0");
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          failures++;
          $display("FAIL resp got rdata=%h err=%b want rdata=%h err=%b",
                   resp_rdata, resp_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h100; req_wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_resp got v=%b d=%h e=%b want 0 0 0", resp_valid, resp_rdata, resp_err);
    end
    checks++;
    if (MemRead !== 1'b0 || MemWrite !== 1'b0 || Address !== 32'h0 || Write_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem got rd=%b wr=%b a=%h wd=%h want all 0",
               MemRead, MemWrite, Address, Write_data);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b want 0", req_ready);
    end
    req_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_word();
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, 1'b0, 1'b1, w);
    checks++;
    if (obs_write !== 1'b1 || obs_read !== 1'b0 || obs_addr !== 32'h100 ||
        obs_wdata !== 32'h1122_3344) begin
      failures++;
      $display("FAIL sw_cycle got wr=%b rd=%b a=%h wd=%h want 1 0 100 11223344",
               obs_write, obs_read, obs_addr, obs_wdata);
    end
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL sw_pulse got MemWrite=%b want 0", MemWrite);
    end
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, w);
    checks++;
    if (obs_read !== 1'b1 || obs_addr !== 32'h100) begin
      failures++;
      $display("FAIL lw_cycle got rd=%b a=%h want 1 100", obs_read, obs_addr);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344) begin
      failures++;
      $display("FAIL lw_latency got v=%b d=%h want 1 11223344", resp_valid, resp_rdata);
    end
    step();
    drain();
  endtask

  task automatic test_subword();
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 1'b1, w);
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 1'b1, w);
    issue(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AA, 1'b0, 1'b1, w);
    checks++;
    if (obs_read !== 1'b1 || obs_write !== 1'b0) begin
      failures++;
      $display("FAIL sb_read_cycle got rd=%b wr=%b want 1 0", obs_read, obs_write);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || MemWrite !== 1'b1 || MemRead !== 1'b0 || Address !== 32'h100 ||
        Write_data !== 32'h11AA_3344) begin
      failures++;
      $display("FAIL sb_rmw_cycle got rdy=%b wr=%b rd=%b a=%h wd=%h want 0 1 0 100 11aa3344",
               req_ready, MemWrite, MemRead, Address, Write_data);
    end
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, w);
    issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h0000_8001, 1'b0, 1'b1, w);
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1, w);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, w);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, w);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, w);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'b00, 1'b0, 32'h104, 32'h0000_00FF, 1'b1, 1'b1, w);
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b0, 1'b1, w);
    checks++;
    if (w !== 1 || obs_read !== 1'b1 || obs_addr !== 32'h104) begin
      failures++;
      $display("FAIL b2b_accept got waits=%0d rd=%b a=%h want 1 1 104", w, obs_read, obs_addr);
    end
    drain();
  endtask

  task automatic test_reset_in_rmw();
    issue(1'b1, 2'b00, 1'b0, 32'h108, 32'h0000_0055, 1'b0, 1'b0, w);
    #1;
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL rmw_before_reset got MemWrite=%b want 1", MemWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmw_reset_drop got wr=%b rdy=%b want 0 0", MemWrite, req_ready);
    end
    last_rdata = 32'h0;
    step();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rmw_reset_noresp got resp_valid=%b want 0", resp_valid);
      end
    end
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 1'b0, 1'b1, w);
    drain();
  endtask

  task automatic test_misalign();
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, 1'b1, w);
    checks++;
`ifdef MEM_MISALIGN_EXC_EN
    if (obs_read !== 1'b0 || obs_write !== 1'b0) begin
      failures++;
      $display("FAIL misalign_lw got rd=%b wr=%b want 0 0", obs_read, obs_write);
    end
`else
    if (obs_read !== 1'b1 || obs_addr !== 32'h100) begin
      failures++;
      $display("FAIL misalign_lw got rd=%b a=%h want 1 100", obs_read, obs_addr);
    end
`endif
    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1'b0, 1'b1, w);
    issue(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b0, 1'b1, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_back_to_back();
    test_reset_in_rmw();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
